// File: rtl/ppfifo_axi_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : ppfifo_axi_stream_mux
// Purpose  : Arbitrates CHANNELS ping-pong FIFO read ports and drains one
//            whole block at a time onto a single AXI Stream master. Each
//            beat carries its source channel on o_axi_dest, and TLAST marks
//            the final word of each block.
// Options  : PPFIFO_AXIS_STRICT_PRIORITY_EN - when defined, the lowest
//            requesting channel index always wins and there is no
//            round-robin pointer.
// Revision : 1.0 - initial release
// ============================================================================
module ppfifo_axi_stream_mux #(
  parameter int DATA_WIDTH    = 32,
  parameter int CHANNELS      = 2,
  parameter int CHAN_ID_WIDTH = 1,
  parameter int SIZE_WIDTH    = 24
) (
  input  logic                                 i_axi_clk,
  input  logic                                 rst,
  input  logic [CHANNELS-1:0]                  i_ppfifo_rdy,
  output logic [CHANNELS-1:0]                  o_ppfifo_act,
  input  logic [CHANNELS*SIZE_WIDTH-1:0]       i_ppfifo_size,
  input  logic [CHANNELS*(DATA_WIDTH+1)-1:0]   i_ppfifo_data,
  output logic [CHANNELS-1:0]                  o_ppfifo_stb,
  input  logic                                 i_axi_ready,
  output logic                                 o_axi_valid,
  output logic [DATA_WIDTH-1:0]                o_axi_data,
  output logic                                 o_axi_last,
  output logic [3:0]                           o_axi_user,
  output logic [CHAN_ID_WIDTH-1:0]             o_axi_dest,
  output logic [31:0]                          o_debug
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVATE = 2'd1,
    ST_STREAM   = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CHANNELS-1:0]       act_q, act_d;
  logic [SIZE_WIDTH-1:0]     count_q, count_d;
  logic [SIZE_WIDTH-1:0]     size_q, size_d;
  logic [CHAN_ID_WIDTH-1:0]  chan_q, chan_d;

  logic [CHANNELS-1:0]       req;
  logic                      pick_found;
  logic [CHAN_ID_WIDTH-1:0]  pick_chan;
  logic [DATA_WIDTH:0]       cur_word;
  logic [SIZE_WIDTH-1:0]     cur_size;
  logic                      valid;
  logic                      handshake;
  logic                      last_beat;

  // A channel that is already activated must not be picked again.
  assign req      = i_ppfifo_rdy & ~act_q;
  assign cur_word = i_ppfifo_data[int'(chan_q)*(DATA_WIDTH+1) +: (DATA_WIDTH+1)];
  assign cur_size = i_ppfifo_size[int'(chan_q)*SIZE_WIDTH +: SIZE_WIDTH];

`ifdef PPFIFO_AXIS_STRICT_PRIORITY_EN
  // Fixed priority: the lowest-index requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_chan  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!pick_found && req[i]) begin
        pick_found = 1'b1;
        pick_chan  = CHAN_ID_WIDTH'(i);
      end
    end
  end
`else
  logic [CHAN_ID_WIDTH-1:0] rr_q, rr_d;

  // Round-robin: search upward from the pointer, wrapping at CHANNELS.
  always_comb begin
    pick_found = 1'b0;
    pick_chan  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!pick_found && req[(int'(rr_q) + i) % CHANNELS]) begin
        pick_found = 1'b1;
        pick_chan  = CHAN_ID_WIDTH'((int'(rr_q) + i) % CHANNELS);
      end
    end
  end

  // The pointer moves past the channel just served once its block is released.
  always_comb begin
    rr_d = rr_q;
    if (state_q == ST_RELEASE) begin
      rr_d = (chan_q == CHAN_ID_WIDTH'(CHANNELS - 1)) ? '0
                                                      : chan_q + CHAN_ID_WIDTH'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge i_axi_clk or posedge rst) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
`endif

  // Beat qualifiers are derived from registers only, so valid cannot glitch
  // on i_axi_ready.
  assign valid     = (state_q == ST_STREAM) && (count_q < size_q);
  assign handshake = valid & i_axi_ready;
  assign last_beat = valid && (count_q == size_q - SIZE_WIDTH'(1));

  // Next-state logic. Leaving STREAM on the final handshake keeps the
  // inter-block gap at RELEASE, IDLE and ACTIVATE only.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    count_d = count_q;
    size_d  = size_q;
    chan_d  = chan_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          chan_d            = pick_chan;
          act_d             = '0;
          act_d[pick_chan]  = 1'b1;
          count_d           = '0;
          state_d           = ST_ACTIVATE;
        end
      end
      ST_ACTIVATE: begin
        size_d  = cur_size;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (handshake) count_d = count_q + SIZE_WIDTH'(1);
        if ((count_q == size_q) || (handshake && last_beat)) begin
          act_d[chan_q] = 1'b0;
          state_d       = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge i_axi_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
      count_q <= '0;
      size_q  <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      count_q <= count_d;
      size_q  <= size_d;
      chan_q  <= chan_d;
    end
  end

  // Only the active channel is popped, and only on an accepted beat.
  always_comb begin
    o_ppfifo_stb         = '0;
    o_ppfifo_stb[chan_q] = handshake;
  end

  assign o_ppfifo_act = act_q;
  assign o_axi_valid  = valid;
  assign o_axi_data   = cur_word[DATA_WIDTH-1:0];
  assign o_axi_last   = last_beat;
  assign o_axi_user   = {3'b000, valid & cur_word[DATA_WIDTH]};
  assign o_axi_dest   = chan_q;
  assign o_debug      = {14'd0, i_axi_ready, valid, 8'(count_q), 4'(chan_q),
                         2'b00, state_q};

endmodule
`default_nettype wire

// File: tb/tb_ppfifo_axi_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppfifo_axi_stream_mux
// Purpose  : Self-checking bench for ppfifo_axi_stream_mux. It uses queued
//            PPFIFO block models and a block-level arbitration and scoreboard
//            model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppfifo_axi_stream_mux;

  localparam int DW  = 32;
  localparam int CH  = 2;
  localparam int CIW = 1;
  localparam int SW  = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     i_ppfifo_rdy;
  logic [CH-1:0]     o_ppfifo_act;
  logic [CH*SW-1:0]  i_ppfifo_size;
  logic [CH*(DW+1)-1:0] i_ppfifo_data;
  logic [CH-1:0]     o_ppfifo_stb;
  logic              i_axi_ready;
  logic              o_axi_valid;
  logic [DW-1:0]     o_axi_data;
  logic              o_axi_last;
  logic [3:0]        o_axi_user;
  logic [CIW-1:0]    o_axi_dest;
  logic [31:0]       o_debug;

  always #5 clk = ~clk;

  ppfifo_axi_stream_mux #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .CHAN_ID_WIDTH(CIW), .SIZE_WIDTH(SW)
  ) dut (
    .i_axi_clk     (clk),
    .rst           (rst),
    .i_ppfifo_rdy  (i_ppfifo_rdy),
    .o_ppfifo_act  (o_ppfifo_act),
    .i_ppfifo_size (i_ppfifo_size),
    .i_ppfifo_data (i_ppfifo_data),
    .o_ppfifo_stb  (o_ppfifo_stb),
    .i_axi_ready   (i_axi_ready),
    .o_axi_valid   (o_axi_valid),
    .o_axi_data    (o_axi_data),
    .o_axi_last    (o_axi_last),
    .o_axi_user    (o_axi_user),
    .o_axi_dest    (o_axi_dest),
    .o_debug       (o_debug)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // PPFIFO contents: per-channel word stream and the sizes of queued blocks.
  logic [DW:0] wq  [CH][$];
  int          bsz [CH][$];

  // Reference state.
  int            cur = -1;
  int            beat = 0;
  int            rr_m = 0;
  int            cyc = 0;
  int            beats_total = 0;
  int            nblocks = 0;
  int            last_end_cyc = 0;
  int            last_gap = 0;
  int            act_age [CH];
  int            ready_mode = 0;
  int            tog_cnt = 0;
  bit            avail_rand = 1'b0;
  logic [CH-1:0] rdy_prev = '0;
  logic [CH-1:0] pv_act = '0;
  logic          pv_valid = 1'b0, pv_ready = 1'b0, pv_last = 1'b0;
  logic [DW-1:0] pv_data = '0;

  function automatic int exp_pick(input logic [CH-1:0] r, input int rr);
`ifdef PPFIFO_AXIS_STRICT_PRIORITY_EN
    for (int i = 0; i < CH; i++) if (r[i]) return i;
`else
    for (int i = 0; i < CH; i++) if (r[(rr + i) % CH]) return (rr + i) % CH;
`endif
    return -1;
  endfunction

  task automatic push_block(input int ch, input int n, input logic [DW-1:0] base, input bit msb0);
    for (int i = 0; i < n; i++) wq[ch].push_back({(msb0 && i == 0), base + DW'(i)});
    bsz[ch].push_back(n);
  endtask

  task automatic push_random_block(input int ch);
    int n;
    n = $urandom_range(0, 6);
    for (int i = 0; i < n; i++) wq[ch].push_back({1'($urandom), DW'($urandom)});
    bsz[ch].push_back(n);
  endtask

  // Drive PPFIFO ports and TREADY for the coming rising edge. Size is only
  // meaningful around activation; afterwards it is scrambled.
  task automatic drive();
    logic [CH-1:0]        r;
    logic [CH*SW-1:0]     s;
    logic [CH*(DW+1)-1:0] d;
    for (int k = 0; k < CH; k++) begin
      bit avail;
      bit have;
      avail = avail_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      have  = bsz[k].size() > 0;
      r[k]  = have && !o_ppfifo_act[k] && avail;
      if (have && (!o_ppfifo_act[k] || act_age[k] == 0)) s[k*SW +: SW] = SW'(bsz[k][0]);
      else                                                s[k*SW +: SW] = SW'($urandom);
      d[k*(DW+1) +: (DW+1)] = (wq[k].size() > 0) ? wq[k][0] : {1'b0, DW'($urandom)};
    end
    i_ppfifo_rdy  = r;
    i_ppfifo_size = s;
    i_ppfifo_data = d;
    case (ready_mode)
      0:       i_axi_ready = 1'b1;
      1:       i_axi_ready = 1'($urandom_range(0, 1));
      default: begin i_axi_ready = (tog_cnt % 3 == 0); tog_cnt++; end
    endcase
  endtask

  // Compare the DUT against the model just before the rising edge.
  task automatic sample();
    logic          hs;
    logic [CH-1:0] emask;
    int            e;
    int            esz;
    logic [DW:0]   w;
    hs = o_axi_valid & i_axi_ready;
    check("dbg_hi", 64'(o_debug[31:16]), {48'd0, 14'd0, i_axi_ready, o_axi_valid});
    check("act_1hot", 64'($onehot0(o_ppfifo_act)), 64'd1);
    if (pv_act == '0 && o_ppfifo_act != '0) begin
      e     = exp_pick(rdy_prev, rr_m);
      emask = (e < 0) ? '0 : (CH'(1) << e);
      check("select", 64'(o_ppfifo_act), 64'(emask));
      cur  = e;
      beat = 0;
    end
    if (!o_axi_valid) begin
      check("user_idle", 64'(o_axi_user), 64'd0);
      check("last_idle", 64'(o_axi_last), 64'd0);
    end
    if (cur >= 0 && bsz[cur].size() > 0) begin
      esz = bsz[cur][0];
      if (o_axi_valid) check("valid_len", 64'(beat < esz), 64'd1);
      if (hs && beat < esz && wq[cur].size() > 0) begin
        w = wq[cur][0];
        check("data", 64'(o_axi_data), 64'(w[DW-1:0]));
        check("user", 64'(o_axi_user), {60'd0, 3'b000, w[DW]});
        check("dest", 64'(o_axi_dest), 64'(cur));
        check("last", 64'(o_axi_last), 64'(beat == esz - 1));
        check("stb", 64'(o_ppfifo_stb), 64'(CH'(1) << cur));
        void'(wq[cur].pop_front());
        if (beat == 0) last_gap = cyc - last_end_cyc;
        if (beat == esz - 1) last_end_cyc = cyc;
        beat++;
        beats_total++;
      end else begin
        check("stb_idle", 64'(o_ppfifo_stb), 64'd0);
      end
    end else begin
      check("no_valid", 64'(o_axi_valid), 64'd0);
      check("no_stb", 64'(o_ppfifo_stb), 64'd0);
    end
    if (pv_valid && !pv_ready) begin
      check("hold_valid", 64'(o_axi_valid), 64'd1);
      check("hold_data", 64'(o_axi_data), 64'(pv_data));
      check("hold_last", 64'(o_axi_last), 64'(pv_last));
    end
    if (pv_valid && pv_ready && !pv_last) check("tput", 64'(o_axi_valid), 64'd1);
    if (pv_valid && pv_ready && pv_last) check("act_fall", 64'(o_ppfifo_act), 64'd0);
    if (pv_act != '0 && o_ppfifo_act == '0 && cur >= 0 && bsz[cur].size() > 0) begin
      check("blk_len", 64'(beat), 64'(bsz[cur][0]));
      void'(bsz[cur].pop_front());
      rr_m = (cur + 1) % CH;
      cur  = -1;
      nblocks++;
    end
    for (int k = 0; k < CH; k++) act_age[k] = o_ppfifo_act[k] ? act_age[k] + 1 : 0;
    rdy_prev = i_ppfifo_rdy;
    pv_act   = o_ppfifo_act;
    pv_valid = o_axi_valid;
    pv_ready = i_axi_ready;
    pv_last  = o_axi_last;
    pv_data  = o_axi_data;
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #4;
    sample();
    cyc++;
  endtask

  function automatic bit busy();
    bit b;
    b = (cur >= 0) || (o_ppfifo_act != '0);
    for (int k = 0; k < CH; k++) if (bsz[k].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_until_idle(input int budget);
    int b;
    b = 0;
    while (busy() && b < budget) begin
      step();
      b++;
    end
    check("drain", 64'(busy()), 64'd0);
  endtask

  task automatic clear_model();
    for (int k = 0; k < CH; k++) begin
      wq[k].delete();
      bsz[k].delete();
      act_age[k] = 0;
    end
    cur = -1; beat = 0; rr_m = 0;
    rdy_prev = '0; pv_act = '0; pv_valid = 1'b0; pv_ready = 1'b0; pv_last = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, n0, k;
    rst = 1'b1;
    i_ppfifo_rdy = '0; i_ppfifo_size = '0; i_ppfifo_data = '0; i_axi_ready = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_act",   64'(o_ppfifo_act), 64'd0);
    check("rst_valid", 64'(o_axi_valid),  64'd0);
    check("rst_last",  64'(o_axi_last),   64'd0);
    check("rst_stb",   64'(o_ppfifo_stb), 64'd0);
    check("rst_dest",  64'(o_axi_dest),   64'd0);
    check("rst_dbg",   64'(o_debug),      64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back blocks at full throughput, then the inter-block gap.
    ready_mode = 0; avail_rand = 1'b0;
    b0 = beats_total;
    push_block(0, 4, 32'h10, 1'b0);
    push_block(1, 2, 32'h30, 1'b0);
    run_until_idle(100);
    check("t1_beats", 64'(beats_total - b0), 64'd6);
    check("t1_gap", 64'(last_gap), 64'd4);

    // Backpressure with ready 1,0,0 repeating.
    ready_mode = 2; tog_cnt = 0;
    b0 = beats_total;
    push_block(0, 4, 32'h20, 1'b0);
    run_until_idle(200);
    check("t2_beats", 64'(beats_total - b0), 64'd4);

    // Both channels contending with size-2 blocks.
    ready_mode = 0;
    b0 = beats_total; n0 = nblocks;
    for (int i = 0; i < 3; i++) begin
      push_block(0, 2, 32'h100 + 32'(i*16), 1'b0);
      push_block(1, 2, 32'h200 + 32'(i*16), 1'b0);
    end
    run_until_idle(300);
    check("t3_beats", 64'(beats_total - b0), 64'd12);
    check("t3_blocks", 64'(nblocks - n0), 64'd6);

    // Zero-size block followed by a block flagging start-of-frame on word 0.
    b0 = beats_total; n0 = nblocks;
    push_block(1, 0, 32'h0, 1'b0);
    step();
    push_block(0, 3, 32'h40, 1'b1);
    run_until_idle(100);
    check("t4_beats", 64'(beats_total - b0), 64'd3);
    check("t4_blocks", 64'(nblocks - n0), 64'd2);

    // Reset in the middle of a block.
    b0 = beats_total;
    push_block(0, 8, 32'h300, 1'b0);
    k = 0;
    while (beats_total - b0 < 2 && k < 50) begin step(); k++; end
    check("t5_two_beats", 64'(beats_total - b0), 64'd2);
    @(negedge clk);
    check("t5_pre_valid", 64'(o_axi_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_act",   64'(o_ppfifo_act), 64'd0);
    check("t5_valid", 64'(o_axi_valid),  64'd0);
    check("t5_stb",   64'(o_ppfifo_stb), 64'd0);
    check("t5_last",  64'(o_axi_last),   64'd0);
    clear_model();
    i_ppfifo_rdy = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b0 = beats_total;
    push_block(0, 8, 32'h400, 1'b0);
    run_until_idle(100);
    check("t5_beats", 64'(beats_total - b0), 64'd8);

    // Randomised traffic with random backpressure and rdy dropouts.
    ready_mode = 1; avail_rand = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, CH - 1);
        if (bsz[k].size() < 3) push_random_block(k);
      end
      step();
    end
    run_until_idle(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
